// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master Wishbone B4 classic arbiter in front of a single SRAM slave.
// Whole Wishbone cycles are granted (CYC-level lock). Masters alternate round-robin
// under contention. A watchdog ends a stalled strobe with an error response.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   m0_*/m1_*          master-side Wishbone ports (cyc/stb/we/adr/dat/sel in; dat/ack/err out)
//   s_*                slave-side Wishbone port (cyc/stb/we/adr/dat/sel out; dat/ack/err in)
//   grant_o            one-hot current owner {m1,m0}; 00 when idle
//   timeout_o          sticky flag: the watchdog has fired since reset
module wb_arbiter2 #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last;     // owner of the most recent grant (1 = m1)
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  logic w_gnt0;
  logic w_gnt1;
  logic w_own_cyc;
  logic w_own_stb;
  logic w_resp;
  logic w_fire;

  assign w_gnt0 = (r_state == GNT0);
  assign w_gnt1 = (r_state == GNT1);

  // Next owner: hold while owner keeps cyc, hand off directly, round-robin on ties.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) w_next = r_last ? GNT0 : GNT1;
        else if (m0_cyc_i)        w_next = GNT0;
        else if (m1_cyc_i)        w_next = GNT1;
      end
      GNT0: if (!m0_cyc_i) w_next = m1_cyc_i ? GNT1 : IDLE;
      GNT1: if (!m1_cyc_i) w_next = m0_cyc_i ? GNT0 : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Slave-side mux, selected purely by the registered owner.
  always_comb begin
    w_own_cyc = 1'b0;
    w_own_stb = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = 32'h0;
    s_dat_o   = 32'h0;
    s_sel_o   = 4'h0;
    if (w_gnt0) begin
      w_own_cyc = m0_cyc_i;
      w_own_stb = m0_stb_i;
      s_we_o    = m0_we_i;
      s_adr_o   = m0_adr_i;
      s_dat_o   = m0_dat_i;
      s_sel_o   = m0_sel_i;
    end else if (w_gnt1) begin
      w_own_cyc = m1_cyc_i;
      w_own_stb = m1_stb_i;
      s_we_o    = m1_we_i;
      s_adr_o   = m1_adr_i;
      s_dat_o   = m1_dat_i;
      s_sel_o   = m1_sel_i;
    end
  end

  // Watchdog fires on the TIMEOUT-th consecutive unanswered strobe cycle.
  assign w_resp = s_ack_i | s_err_i;
  assign w_fire = w_own_cyc & w_own_stb & ~w_resp & (r_cnt == CNT_W'(TIMEOUT - 1));

  assign s_cyc_o = w_own_cyc;
  assign s_stb_o = w_own_stb & ~w_fire;  // strobe withdrawn in the error cycle

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & w_gnt0;
  assign m1_ack_o = s_ack_i & w_gnt1;
  assign m0_err_o = (s_err_i | w_fire) & w_gnt0;
  assign m1_err_o = (s_err_i | w_fire) & w_gnt1;

  assign grant_o   = {w_gnt1, w_gnt0};
  assign timeout_o = r_timeout;

  // State, round-robin history, watchdog counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == GNT0) r_last <= 1'b0;
      if (w_next == GNT1) r_last <= 1'b1;
      if (w_own_cyc && w_own_stb && !w_resp && !w_fire) r_cnt <= r_cnt + CNT_W'(1);
      else                                              r_cnt <= '0;
      if (w_fire) r_timeout <= 1'b1;
    end
  end

endmodule
